// File: rtl/fwd_pkg.sv
// Shared types for the forwarding data path: select codes and the
// per-slot record tracking one in-flight instruction's result.
package fwd_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int REG_BITS   = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_PC4  = 2'd1,
      FWD_PC8  = 2'd2,
      FWD_PC12 = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic                  write;
      logic                  ready;
      logic [REG_BITS-1:0]   dest;
      logic [DATA_WIDTH-1:0] data;
   } slot_t;

endpackage

// File: rtl/fwd_slot_mux.sv
// Combinational operand picker: one select code against the three slots.
// Ports: i_sel, i_s1..i_s3 in; o_value, o_hazard (not ready), o_err (non-writer).
module fwd_slot_mux
   import fwd_pkg::*;
(
   input  logic [1:0]            i_sel,
   input  slot_t                 i_s1,
   input  slot_t                 i_s2,
   input  slot_t                 i_s3,
   output logic [DATA_WIDTH-1:0] o_value,
   output logic                  o_hazard,
   output logic                  o_err
);

   slot_t w_slot;
   logic  w_hit;
   logic  w_unused_dest;

   assign w_unused_dest = ^{i_s1.dest, i_s2.dest, i_s3.dest};

   always_comb begin
      w_slot = '0;
      w_hit  = (i_sel != FWD_NONE);
      unique case (1'b1)
         (i_sel == FWD_PC4):  w_slot = i_s1;
         (i_sel == FWD_PC8):  w_slot = i_s2;
         (i_sel == FWD_PC12): w_slot = i_s3;
         default:             w_slot = '0;
      endcase
   end

   // A non-writing slot never forwards; it only flags a bad select.
   assign o_value  = w_slot.write ? w_slot.data : '0;
   assign o_hazard = w_hit & w_slot.write & ~w_slot.ready;
   assign o_err    = w_hit & ~w_slot.write;

endmodule

// File: rtl/forward_result_buffer.sv
// Tracks the last three issued instructions, captures their results and
// serves forwarded operands for PC-4/8/12 selects; flags load-use hazards.
// Ports: CLK/RESET, stall_in, issue_*, alu_fill_*, mem_fill_*, sel_*;
// out fwd_a/b/mem, data_hazard, sticky sel_err, saturating hazard_cycles.
module forward_result_buffer
   import fwd_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  stall_in,
   input  logic                  issue_valid,
   input  logic                  issue_reg_write,
   input  logic [REG_BITS-1:0]   issue_dest,
   input  logic                  alu_fill_valid,
   input  logic [DATA_WIDTH-1:0] alu_fill_data,
   input  logic                  mem_fill_valid,
   input  logic [DATA_WIDTH-1:0] mem_fill_data,
   input  logic [1:0]            sel_a,
   input  logic [1:0]            sel_b,
   input  logic [1:0]            sel_mem,
   output logic [DATA_WIDTH-1:0] fwd_a,
   output logic [DATA_WIDTH-1:0] fwd_b,
   output logic [DATA_WIDTH-1:0] fwd_mem,
   output logic                  data_hazard,
   output logic                  sel_err,
   output logic [CNT_WIDTH-1:0]  hazard_cycles
);

   slot_t                r_s1;
   slot_t                r_s2;
   slot_t                r_s3;
   logic                 r_sel_err;
   logic [CNT_WIDTH-1:0] r_hazard_cycles;

   slot_t w_s1_fill;
   slot_t w_s2_fill;
   slot_t w_issue;
   logic  w_haz_a, w_haz_b, w_haz_m;
   logic  w_err_a, w_err_b, w_err_m;

   // Fills act on the pre-edge slot; the result then shifts with it.
   always_comb begin
      w_s1_fill = r_s1;
      if (alu_fill_valid && r_s1.write) begin
         w_s1_fill.data  = alu_fill_data;
         w_s1_fill.ready = 1'b1;
      end
      w_s2_fill = r_s2;
      if (mem_fill_valid && r_s2.write) begin
         w_s2_fill.data  = mem_fill_data;
         w_s2_fill.ready = 1'b1;
      end
   end

   // r0 is never a real producer.
   always_comb begin
      w_issue       = '0;
      w_issue.write = issue_valid & issue_reg_write & (issue_dest != '0);
      w_issue.dest  = issue_dest;
   end

   fwd_slot_mux u_mux_a (
      .i_sel    (sel_a),
      .i_s1     (r_s1),
      .i_s2     (r_s2),
      .i_s3     (r_s3),
      .o_value  (fwd_a),
      .o_hazard (w_haz_a),
      .o_err    (w_err_a)
   );

   fwd_slot_mux u_mux_b (
      .i_sel    (sel_b),
      .i_s1     (r_s1),
      .i_s2     (r_s2),
      .i_s3     (r_s3),
      .o_value  (fwd_b),
      .o_hazard (w_haz_b),
      .o_err    (w_err_b)
   );

   fwd_slot_mux u_mux_m (
      .i_sel    (sel_mem),
      .i_s1     (r_s1),
      .i_s2     (r_s2),
      .i_s3     (r_s3),
      .o_value  (fwd_mem),
      .o_hazard (w_haz_m),
      .o_err    (w_err_m)
   );

   assign data_hazard   = w_haz_a | w_haz_b | w_haz_m;
   assign sel_err       = r_sel_err;
   assign hazard_cycles = r_hazard_cycles;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_s1            <= '0;
         r_s2            <= '0;
         r_s3            <= '0;
         r_sel_err       <= 1'b0;
         r_hazard_cycles <= '0;
      end else begin
         if (!stall_in) begin
            r_s3 <= w_s2_fill;
            r_s2 <= w_s1_fill;
            r_s1 <= w_issue;
         end else begin
            r_s1 <= w_s1_fill;
            r_s2 <= w_s2_fill;
         end
         r_sel_err <= r_sel_err | w_err_a | w_err_b | w_err_m;
         if (data_hazard && (r_hazard_cycles != '1)) begin
            r_hazard_cycles <= r_hazard_cycles + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_forward_result_buffer.sv
// Bench for forward_result_buffer: directed scenarios with literal
// expectations, then random traffic against an in-bench slot model.
module tb_forward_result_buffer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        stall_in;
   logic        issue_valid;
   logic        issue_reg_write;
   logic [4:0]  issue_dest;
   logic        alu_fill_valid;
   logic [31:0] alu_fill_data;
   logic        mem_fill_valid;
   logic [31:0] mem_fill_data;
   logic [1:0]  sel_a, sel_b, sel_mem;
   logic [31:0] fwd_a, fwd_b, fwd_mem;
   logic        data_hazard;
   logic        sel_err;
   logic [15:0] hazard_cycles;

   int checks = 0;
   int errors = 0;

   // Model: index 1..3 = PC-4, PC-8, PC-12 producers.
   bit          mw [1:3];
   bit          mr [1:3];
   logic [31:0] md [1:3];
   bit          merr;
   int          mcnt;
   bit          mvalid = 0;

   forward_result_buffer #(.CNT_WIDTH(16)) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .stall_in        (stall_in),
      .issue_valid     (issue_valid),
      .issue_reg_write (issue_reg_write),
      .issue_dest      (issue_dest),
      .alu_fill_valid  (alu_fill_valid),
      .alu_fill_data   (alu_fill_data),
      .mem_fill_valid  (mem_fill_valid),
      .mem_fill_data   (mem_fill_data),
      .sel_a           (sel_a),
      .sel_b           (sel_b),
      .sel_mem         (sel_mem),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .fwd_mem         (fwd_mem),
      .data_hazard     (data_hazard),
      .sel_err         (sel_err),
      .hazard_cycles   (hazard_cycles)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic logic [31:0] exp_val(input logic [1:0] s);
      if (s == 0) return 32'h0;
      return mw[s] ? md[s] : 32'h0;
   endfunction

   function automatic bit exp_haz(input logic [1:0] s);
      if (s == 0) return 1'b0;
      return mw[s] && !mr[s];
   endfunction

   function automatic bit exp_bad(input logic [1:0] s);
      if (s == 0) return 1'b0;
      return !mw[s];
   endfunction

   task automatic compare();
      bit h;
      h = exp_haz(sel_a) | exp_haz(sel_b) | exp_haz(sel_mem);
      chk("fwd_a", fwd_a, exp_val(sel_a));
      chk("fwd_b", fwd_b, exp_val(sel_b));
      chk("fwd_mem", fwd_mem, exp_val(sel_mem));
      chk("data_hazard", {31'b0, data_hazard}, {31'b0, h});
      chk("sel_err", {31'b0, sel_err}, {31'b0, merr});
      chk("hazard_cycles", {16'b0, hazard_cycles}, mcnt);
   endtask

   // One clock: check at negedge, then move the model across the edge.
   task automatic tick();
      bit          nw [1:3];
      bit          nr [1:3];
      logic [31:0] nd [1:3];
      bit          nerr;
      int          ncnt;
      bit          h;
      @(negedge CLK);
      if (mvalid) compare();
      for (int i = 1; i <= 3; i++) begin
         nw[i] = mw[i]; nr[i] = mr[i]; nd[i] = md[i];
      end
      if (alu_fill_valid && mw[1]) begin nd[1] = alu_fill_data; nr[1] = 1; end
      if (mem_fill_valid && mw[2]) begin nd[2] = mem_fill_data; nr[2] = 1; end
      h = exp_haz(sel_a) | exp_haz(sel_b) | exp_haz(sel_mem);
      nerr = merr | exp_bad(sel_a) | exp_bad(sel_b) | exp_bad(sel_mem);
      ncnt = (h && mcnt < 65535) ? mcnt + 1 : mcnt;
      if (!stall_in) begin
         nw[3] = nw[2]; nr[3] = nr[2]; nd[3] = nd[2];
         nw[2] = nw[1]; nr[2] = nr[1]; nd[2] = nd[1];
         nw[1] = issue_valid && issue_reg_write && issue_dest != 0;
         nr[1] = 0;
         nd[1] = 0;
      end
      if (RESET) begin
         for (int i = 1; i <= 3; i++) begin
            nw[i] = 0; nr[i] = 0; nd[i] = 0;
         end
         nerr = 0;
         ncnt = 0;
      end
      @(posedge CLK);
      #1;
      for (int i = 1; i <= 3; i++) begin
         mw[i] = nw[i]; mr[i] = nr[i]; md[i] = nd[i];
      end
      merr = nerr;
      mcnt = ncnt;
      if (RESET) mvalid = 1;
   endtask

   task automatic idle();
      stall_in = 0; issue_valid = 0; issue_reg_write = 0; issue_dest = 0;
      alu_fill_valid = 0; alu_fill_data = 0;
      mem_fill_valid = 0; mem_fill_data = 0;
      sel_a = 0; sel_b = 0; sel_mem = 0;
   endtask

   task automatic do_reset();
      idle();
      RESET = 1;
      tick();
      RESET = 0;
   endtask

   task automatic issue(input logic [4:0] d);
      issue_valid = 1; issue_reg_write = 1; issue_dest = d;
   endtask

   initial begin
      RESET = 0;
      idle();
      do_reset();
      chk("rst_fwd_a", fwd_a, 32'h0);
      chk("rst_fwd_b", fwd_b, 32'h0);
      chk("rst_fwd_mem", fwd_mem, 32'h0);
      chk("rst_hazard", {31'b0, data_hazard}, 32'h0);
      chk("rst_sel_err", {31'b0, sel_err}, 32'h0);
      chk("rst_cnt", {16'b0, hazard_cycles}, 32'h0);

      // r5 producer filled while held in PC-4
      issue(5); tick(); idle();
      stall_in = 1; alu_fill_valid = 1; alu_fill_data = 32'h1234; tick();
      idle(); sel_a = 1; #1;
      chk("r5_fwd_a", fwd_a, 32'h1234);
      chk("r5_hazard", {31'b0, data_hazard}, 32'h0);

      // load to r7: load-use hazard, then mem fill lands in PC-12
      idle(); issue(7); tick(); idle();
      sel_b = 1; #1;
      chk("ld_hazard", {31'b0, data_hazard}, 32'h1);
      chk("ld_cnt0", {16'b0, hazard_cycles}, 32'h0);
      stall_in = 1; tick();
      chk("ld_cnt1", {16'b0, hazard_cycles}, 32'h1);
      idle(); tick();
      sel_b = 2; #1;
      chk("ld_haz_pc8", {31'b0, data_hazard}, 32'h1);
      mem_fill_valid = 1; mem_fill_data = 32'hDEAD; tick();
      idle(); sel_b = 3; #1;
      chk("ld_fwd_b", fwd_b, 32'hDEAD);
      chk("ld_haz_clr", {31'b0, data_hazard}, 32'h0);
      chk("ld_cnt2", {16'b0, hazard_cycles}, 32'h2);

      // three back-to-back writers
      do_reset();
      issue(1); tick();
      issue(2); alu_fill_valid = 1; alu_fill_data = 32'h11; tick();
      issue(3); alu_fill_valid = 1; alu_fill_data = 32'h22; tick();
      idle(); stall_in = 1; alu_fill_valid = 1; alu_fill_data = 32'h33; tick();
      idle(); sel_a = 3; sel_b = 2; sel_mem = 1; #1;
      chk("b2b_a", fwd_a, 32'h11);
      chk("b2b_b", fwd_b, 32'h22);
      chk("b2b_mem", fwd_mem, 32'h33);
      chk("b2b_haz", {31'b0, data_hazard}, 32'h0);

      // write to r0 is not a producer
      do_reset();
      issue(0); tick(); idle();
      sel_a = 1; #1;
      chk("r0_fwd_a", fwd_a, 32'h0);
      chk("r0_haz", {31'b0, data_hazard}, 32'h0);
      chk("r0_err_pre", {31'b0, sel_err}, 32'h0);
      tick(); idle();
      chk("r0_err", {31'b0, sel_err}, 32'h1);
      repeat (10) tick();
      chk("r0_err_sticky", {31'b0, sel_err}, 32'h1);

      // long stall with pending PC-4 producer
      do_reset();
      issue(9); tick(); idle();
      stall_in = 1;
      repeat (4) tick();
      alu_fill_valid = 1; alu_fill_data = 32'h5A5A; tick();
      alu_fill_valid = 0; sel_a = 1; #1;
      chk("stall_fwd_a", fwd_a, 32'h5A5A);

      // counter saturation, then reset mid-hazard
      do_reset();
      issue(4); tick(); idle();
      stall_in = 1; sel_a = 1;
      repeat (65539) tick();
      chk("sat_cnt", {16'b0, hazard_cycles}, 32'hFFFF);
      chk("sat_haz", {31'b0, data_hazard}, 32'h1);
      RESET = 1; tick(); RESET = 0;
      chk("rh_fwd_a", fwd_a, 32'h0);
      chk("rh_haz", {31'b0, data_hazard}, 32'h0);
      chk("rh_cnt", {16'b0, hazard_cycles}, 32'h0);
      chk("rh_err", {31'b0, sel_err}, 32'h0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         RESET           = ($urandom_range(0, 99) == 0);
         stall_in        = ($urandom_range(0, 3) == 0);
         issue_valid     = $urandom_range(0, 1);
         issue_reg_write = ($urandom_range(0, 3) != 0);
         issue_dest      = ($urandom_range(0, 7) == 0) ? 5'd0 :
                           5'($urandom_range(1, 31));
         alu_fill_valid  = $urandom_range(0, 1);
         alu_fill_data   = $urandom;
         mem_fill_valid  = $urandom_range(0, 1);
         mem_fill_data   = $urandom;
         sel_a           = 2'($urandom_range(0, 3));
         sel_b           = 2'($urandom_range(0, 3));
         sel_mem         = 2'($urandom_range(0, 3));
         tick();
      end
      RESET = 0; idle(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
